keypad_decoder: RTL and testbench

Consumes the column strobe and row sample produced by the 4x4 keypad scanner and turns them into debounced key events. Each full scan of the four columns is one frame. A key is reported only after it has been seen alone for several consecutive frames. Sits between the scanner and the application logic (display / entry FSM), on the same single clock as the scanner.

---
 rtl/keypad_pkg.sv | 70 +++++++
 rtl/keypad_frame.sv | 90 +++++++++
 rtl/keypad_decoder.sv | 117 +++++++++++
 tb/tb_keypad_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key codes and the key-map lookup
// for the 4x4 keypad decoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_KEY,
    FR_MULTI
  } frame_kind_t;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [2:0] popcount4(
    input logic [3:0] v
  );
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]}
              + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [3:0] key_lookup(
    input logic [3:0] col_onehot,
    input logic [3:0] row_onehot
  );
    logic [1:0] c;
    logic [1:0] r;
    unique case (1'b1)
      col_onehot[3]: c = 2'd0;
      col_onehot[2]: c = 2'd1;
      col_onehot[1]: c = 2'd2;
      default:       c = 2'd3;
    endcase
    unique case (1'b1)
      row_onehot[0]: r = 2'd0;
      row_onehot[1]: r = 2'd1;
      row_onehot[2]: r = 2'd2;
      default:       r = 2'd3;
    endcase
    if (c == 2'd3) begin
      unique case (r)
        2'd0:    key_lookup = KEY_A;
        2'd1:    key_lookup = KEY_B;
        2'd2:    key_lookup = KEY_C;
        default: key_lookup = KEY_D;
      endcase
    end else if (r != 2'd3) begin
      key_lookup = {2'b00, r} * 4'd3
                 + {2'b00, c} + 4'd1;
    end else if (c == 2'd0) begin
      key_lookup = KEY_STAR;
    end else if (c == 2'd1) begin
      key_lookup = KEY_0;
    end else begin
      key_lookup = KEY_HASH;
    end
  endfunction

endpackage

// File: rtl/keypad_frame.sv
// keypad_frame: column-transition capture and per-frame hit
// accumulation; classifies each finished frame.
module keypad_frame
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  columns,
  input  logic [3:0]  sample,
  output logic        frame_end,
  output frame_kind_t frame_kind,
  output logic [3:0]  frame_code
);

  logic [3:0] columns_q;
  logic [3:0] sample_q;
  logic [3:0] seen_q;
  logic [3:0] code_q;
  logic [1:0] hits_q;
  logic       multi_q;
  logic       primed_q;

  logic       trans;
  logic [2:0] sum;
  logic [3:0] seen_n;
  logic [3:0] code_n;
  logic [1:0] hits_n;
  logic       multi_n;

  assign trans     = columns != columns_q;
  assign frame_end = trans && (columns == 4'b1000);
  assign sum       = {1'b0, hits_q} + popcount4(sample_q);

  always_comb begin
    seen_n  = seen_q;
    code_n  = code_q;
    hits_n  = hits_q;
    multi_n = multi_q;
    if (trans) begin
      if (!$onehot(columns_q)) begin
        multi_n = 1'b1;
      end else begin
        seen_n = seen_q | columns_q;
        hits_n = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        if ($onehot(sample_q))
          code_n = key_lookup(columns_q, sample_q);
      end
    end
  end

  // The first frame after reset only counts if every column was seen.
  always_comb begin
    frame_code = code_n;
    if (multi_n || hits_n == 2'd2 ||
        (!primed_q && seen_n != 4'hF))
      frame_kind = FR_MULTI;
    else if (hits_n == 2'd1)
      frame_kind = FR_KEY;
    else
      frame_kind = FR_NONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      columns_q <= 4'h0;
      sample_q  <= 4'h0;
      seen_q    <= 4'h0;
      code_q    <= 4'h0;
      hits_q    <= 2'd0;
      multi_q   <= 1'b0;
      primed_q  <= 1'b0;
    end else begin
      columns_q <= columns;
      sample_q  <= sample;
      if (frame_end) begin
        code_q   <= 4'h0;
        hits_q   <= 2'd0;
        multi_q  <= 1'b0;
        primed_q <= 1'b1;
        seen_q   <= seen_n;
      end else begin
        seen_q  <= seen_n;
        code_q  <= code_n;
        hits_q  <= hits_n;
        multi_q <= multi_n;
      end
    end
  end

endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder: frame-level debounce FSM turning keypad scan
// frames into key_valid / key_held / key_code.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int STABLE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columns,
  input  logic [3:0] sample,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] STABLE = 4'(STABLE_FRAMES);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  cand;
  logic [3:0]  cnt_inc;
  logic        frame_end;
  frame_kind_t frame_kind;
  logic [3:0]  frame_code;
  logic        hit;
  logic        hit_cand;
  logic        hit_code;

  keypad_frame u_frame (
    .clk        (clk),
    .reset      (reset),
    .columns    (columns),
    .sample     (sample),
    .frame_end  (frame_end),
    .frame_kind (frame_kind),
    .frame_code (frame_code)
  );

  assign cnt_inc  = cnt + 4'd1;
  assign hit      = frame_kind == FR_KEY;
  assign hit_cand = hit && (frame_code == cand);
  assign hit_code = hit && (frame_code == key_code);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cand      <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        unique case (state)
          IDLE: begin
            if (hit) begin
              cand <= frame_code;
              cnt  <= 4'd1;
              if (STABLE == 4'd1) begin
                state     <= PRESSED;
                key_code  <= frame_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= DEB_PRESS;
              end
            end
          end
          DEB_PRESS: begin
            if (hit_cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == STABLE) begin
                state     <= PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else if (hit) begin
              cand <= frame_code;
              cnt  <= 4'd1;
            end else begin
              state <= IDLE;
              cnt   <= 4'd0;
            end
          end
          PRESSED: begin
            if (!hit_code) begin
              cnt <= 4'd1;
              if (STABLE == 4'd1) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end else begin
                state <= DEB_RELEASE;
              end
            end
          end
          DEB_RELEASE: begin
            if (hit_code) begin
              state <= PRESSED;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == STABLE) begin
                state    <= IDLE;
                key_held <= 1'b0;
                cnt      <= 4'd0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: frame-level reference model checked every
// cycle against two decoders (STABLE_FRAMES = 3 and 1).
module tb_keypad_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] columns = 4'h0;
  logic [3:0] sample = 4'h0;
  logic [3:0] key_code, code1;
  logic       key_valid, valid1;
  logic       key_held, held1;

  always #5 clk = ~clk;

  keypad_decoder #(.STABLE_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .columns(columns), .sample(sample),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  keypad_decoder #(.STABLE_FRAMES(1)) dut1 (
    .clk(clk), .reset(reset), .columns(columns), .sample(sample),
    .key_code(code1), .key_valid(valid1), .key_held(held1)
  );

  // Row-major key map: index = row*4 + col.
  logic [3:0] kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  int total = 0;
  int passed = 0;
  int pulses [2];

  int         m_st  [2];
  int         m_cnt [2];
  logic [3:0] m_cand[2];
  logic [3:0] m_code[2];
  logic       m_valid[2];
  logic       m_held[2];

  logic [3:0] prev_c, prev_s, f_code;
  bit   [3:0] seen;
  int         f_hits;
  bit         f_multi, primed;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic model_reset();
    prev_c = 4'h0; prev_s = 4'h0; f_code = 4'h0;
    seen = 4'h0; f_hits = 0; f_multi = 0; primed = 0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_cand[i] = 4'h0;
      m_code[i] = 4'h0; m_valid[i] = 0; m_held[i] = 0;
    end
  endtask

  task automatic accept(input int i);
    m_st[i] = 2; m_code[i] = m_cand[i];
    m_valid[i] = 1; m_held[i] = 1;
  endtask

  task automatic drop(input int i);
    m_st[i] = 0; m_held[i] = 0;
  endtask

  // States: 0 idle, 1 debouncing press, 2 pressed, 3 debouncing release.
  task automatic model_frame(input int i, input int s,
                             input int kind, input logic [3:0] code);
    logic hit;
    hit = (kind == 1);
    case (m_st[i])
      0: if (hit) begin
        m_cand[i] = code; m_cnt[i] = 1;
        if (m_cnt[i] >= s) accept(i); else m_st[i] = 1;
      end
      1: if (hit && code == m_cand[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] >= s) accept(i);
      end else if (hit) begin
        m_cand[i] = code; m_cnt[i] = 1;
      end else m_st[i] = 0;
      2: if (!(hit && code == m_code[i])) begin
        m_cnt[i] = 1;
        if (m_cnt[i] >= s) drop(i); else m_st[i] = 3;
      end
      default: if (hit && code == m_code[i]) m_st[i] = 2;
      else begin
        m_cnt[i]++;
        if (m_cnt[i] >= s) drop(i);
      end
    endcase
  endtask

  task automatic attribute(input logic [3:0] pc, input logic [3:0] ps,
                           input bit fend);
    int col, n, kind;
    col = -1;
    for (int k = 0; k < 4; k++) if (pc == (4'b1000 >> k)) col = k;
    if (col < 0) f_multi = 1;
    else begin
      seen[col] = 1'b1;
      n = $countones(ps);
      f_hits += n;
      if (n == 1)
        for (int k = 0; k < 4; k++) if (ps[k]) f_code = kmap[k*4 + col];
    end
    if (fend) begin
      if (f_multi || f_hits >= 2 || (!primed && seen != 4'hF)) kind = 2;
      else kind = (f_hits == 1) ? 1 : 0;
      model_frame(0, 3, kind, f_code);
      model_frame(1, 1, kind, f_code);
      f_hits = 0; f_multi = 0; f_code = 4'h0; primed = 1;
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [3:0] s,
                      input logic r);
    @(negedge clk);
    reset = r; columns = c; sample = s;
    for (int i = 0; i < 2; i++) m_valid[i] = 0;
    if (r) model_reset();
    else begin
      if (c != prev_c) attribute(prev_c, prev_s, c == 4'b1000);
      prev_c = c; prev_s = s;
    end
  endtask

  task automatic frame(input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3);
    logic [3:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) step(4'b1000 >> k, s[k], 1'b0);
  endtask

  task automatic rframe(input logic [3:0] s0, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] s3);
    logic [3:0] s [4];
    logic [3:0] c, v;
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) begin
        c = 4'b1000 >> k;
        v = s[k];
        if (j < 7 && $urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 299) == 0) c = 4'($urandom_range(0, 15));
        step(c, v, $urandom_range(0, 799) == 0);
      end
  endtask

  task automatic nframes(input int n, input logic [3:0] s0,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] s3);
    for (int f = 0; f < n; f++) frame(s0, s1, s2, s3);
  endtask

  initial begin
    pulses[0] = 0; pulses[1] = 0;
    forever begin
      @(posedge clk); #1;
      check("code", key_code, m_code[0]);
      check("valid", key_valid, m_valid[0]);
      check("held", key_held, m_held[0]);
      check("code_s1", code1, m_code[1]);
      check("valid_s1", valid1, m_valid[1]);
      check("held_s1", held1, m_held[1]);
      if (key_valid) pulses[0]++;
      if (valid1) pulses[1]++;
    end
  end

  initial begin
    int hold, kind, kr, kc;
    logic [3:0] s [4];
    model_reset();
    for (int i = 0; i < 10; i++) step(4'b1000, 4'h0, 1'b1);
    nframes(4, 0, 0, 0, 0);
    check("idle_pulses", 8'(pulses[0]), 0);
    check("idle_code", key_code, 0);
    check("idle_held", key_held, 0);

    nframes(3, 4'b0001, 0, 0, 0);
    #6;
    check("k1_before", key_held, 0);
    check("k1_s1_held", held1, 1);
    check("k1_s1_code", code1, 4'h1);
    step(4'b1000, 4'b0001, 1'b0);
    #6;
    check("k1_valid", key_valid, 1);
    check("k1_held", key_held, 1);
    check("k1_code", key_code, 4'h1);
    nframes(10, 4'b0001, 0, 0, 0);
    check("k1_no_repeat", 8'(pulses[0]), 1);
    check("k1_s1_pulses", 8'(pulses[1]), 1);

    nframes(2, 0, 0, 0, 0);
    check("rel_deb_held", key_held, 1);
    check("rel_s1_held", held1, 0);
    nframes(2, 0, 0, 0, 0);
    check("rel_held", key_held, 0);
    check("rel_code_kept", key_code, 4'h1);

    nframes(4, 0, 0, 0, 4'b1000);
    check("kd_code", key_code, 4'hD);
    check("kd_held", key_held, 1);
    nframes(3, 0, 0, 0, 0);
    #6;
    check("kd_still_held", key_held, 1);
    step(4'b1000, 4'h0, 1'b0);
    #6;
    check("kd_released", key_held, 0);
    check("kd_code_kept", key_code, 4'hD);
    nframes(1, 0, 0, 0, 0);

    nframes(5, 0, 4'b0011, 0, 0);
    check("multi_pulses", 8'(pulses[0]), 2);
    check("multi_held", key_held, 0);

    nframes(2, 0, 4'b0010, 0, 0);
    nframes(1, 0, 0, 0, 0);
    nframes(3, 0, 4'b0010, 0, 0);
    check("k5_early", 8'(pulses[0]), 2);
    step(4'b1000, 4'h0, 1'b0);
    #6;
    check("k5_valid", key_valid, 1);
    check("k5_code", key_code, 4'h5);
    nframes(1, 0, 4'b0010, 0, 0);
    nframes(1, 0, 0, 0, 0);
    nframes(3, 0, 4'b0010, 0, 0);
    check("k5_glitch_held", key_held, 1);
    check("k5_glitch_pulses", 8'(pulses[0]), 3);

    nframes(4, 0, 0, 0, 0);
    nframes(2, 4'b0100, 0, 0, 0);
    step(4'b1000, 4'h0, 1'b1);
    #1;
    check("rst_dp_code", key_code, 0);
    for (int i = 0; i < 12; i++) step(4'b1000, 4'h0, 1'b1);
    nframes(3, 4'b0100, 0, 0, 0);
    #6;
    check("k7_before", key_held, 0);
    step(4'b1000, 4'b0100, 1'b0);
    #6;
    check("k7_valid", key_valid, 1);
    check("k7_code", key_code, 4'h7);
    nframes(2, 4'b0100, 0, 0, 0);
    step(4'b0100, 4'h0, 1'b1);
    #1;
    check("rst_pr_held", key_held, 0);
    check("rst_pr_code", key_code, 0);
    for (int i = 0; i < 5; i++) step(4'b1000, 4'h0, 1'b1);
    nframes(3, 4'b0100, 0, 0, 0);
    check("k7b_early", 8'(pulses[0]), 4);
    nframes(1, 4'b0100, 0, 0, 0);
    check("k7b_pulses", 8'(pulses[0]), 5);

    hold = 0; kind = 0; kr = 0; kc = 0;
    for (int f = 0; f < 160; f++) begin
      if (hold == 0) begin
        kind = $urandom_range(0, 9);
        kr = $urandom_range(0, 3);
        kc = $urandom_range(0, 3);
        hold = $urandom_range(1, 6);
      end
      hold--;
      foreach (s[k]) s[k] = 4'h0;
      if (kind < 6 || kind > 7) s[kc][kr] = 1'b1;
      if (kind > 7) s[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      if ($urandom_range(0, 7) == 0)
        s[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      rframe(s[0], s[1], s[2], s[3]);
    end
    nframes(5, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
